// File: rtl/iob_cycle_responder.sv
// FSB-side responder for slow I/O bus cycles: latches cycle attributes, runs a 4-phase REQ/ACK handshake, returns nDTACK or nBERR.
// Optional posted RAM-region writes are enabled by defining IOB_POSTED_WRITE_EN.
module iob_cycle_responder #(
  parameter int TIMEOUT     = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RES,
  input  logic BACT,
  input  logic IOCS,
  input  logic IACS,
  input  logic SCSICS,
  input  logic IOPWCS,
  input  logic nWE,
  input  logic IOACK,
  output logic IOREQ,
  output logic IOWE,
  output logic IOIACK,
  output logic IOSCSI,
  output logic IOBUSY,
  output logic nDTACK,
  output logic nBERR
);

`ifdef IOB_POSTED_WRITE_EN
  localparam bit PW_EN = 1'b1;
`else
  localparam bit PW_EN = 1'b0;
`endif

  localparam logic [7:0] TC = 8'(TIMEOUT - 1);

  // IDLE wait start | REQ IOREQ high | RELEASE wait ACK low | TERM nDTACK low | ABORT nBERR low
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RELEASE, S_TERM, S_ABORT} state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_go;

  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic [7:0]             r_cnt;
  logic                   r_iowe;
  logic                   r_ioiack;
  logic                   r_ioscsi;
  logic                   r_posted;
  logic                   r_pdtack;
  logic                   r_aborted;

  logic w_acks;
  logic w_start;
  logic w_pw_req;
  logic w_cpu_gone;
  logic w_tc;

  assign w_acks     = r_ack_sync[SYNC_STAGES-1];
  assign w_start    = BACT & (IOCS | IACS);
  assign w_pw_req   = PW_EN & BACT & IOPWCS & IOCS & ~nWE;
  assign w_cpu_gone = r_aborted | ~BACT;
  assign w_tc       = (r_cnt == TC);

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) r_ack_sync <= '0;
    else     r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], IOACK};
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // A pending posted acknowledge blocks restart so the same CPU cycle is not serviced twice.
  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start && !w_acks && !r_pdtack) begin
          w_state_nxt = S_REQ;
          w_go        = 1'b1;
        end
      end
      S_REQ: begin
        if (w_acks)    w_state_nxt = S_RELEASE;
        else if (w_tc) w_state_nxt = (r_posted || w_cpu_gone) ? S_IDLE : S_ABORT;
      end
      S_RELEASE: begin
        if (!w_acks) w_state_nxt = (r_posted || w_cpu_gone) ? S_IDLE : S_TERM;
      end
      S_TERM: begin
        if (!BACT) w_state_nxt = S_IDLE;
      end
      S_ABORT: begin
        if (!BACT && !w_acks) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_cnt     <= '0;
      r_iowe    <= 1'b0;
      r_ioiack  <= 1'b0;
      r_ioscsi  <= 1'b0;
      r_posted  <= 1'b0;
      r_aborted <= 1'b0;
      r_pdtack  <= 1'b0;
    end else begin
      if (w_go) begin
        r_iowe    <= ~nWE;
        r_ioiack  <= IACS;
        r_ioscsi  <= SCSICS;
        r_posted  <= w_pw_req;
        r_cnt     <= '0;
        r_aborted <= 1'b0;
      end else begin
        if (r_state == S_REQ && r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
        if ((r_state == S_REQ || r_state == S_RELEASE) && !BACT) r_aborted <= 1'b1;
        if (w_state_nxt == S_IDLE) r_posted <= 1'b0;
      end
      if (w_go && w_pw_req) r_pdtack <= 1'b1;
      else if (!BACT)       r_pdtack <= 1'b0;
    end
  end

  assign IOREQ  = (r_state == S_REQ);
  assign IOBUSY = (r_state == S_REQ) || (r_state == S_RELEASE);
  assign IOWE   = r_iowe;
  assign IOIACK = r_ioiack;
  assign IOSCSI = r_ioscsi;
  assign nDTACK = ~((r_state == S_TERM) | r_pdtack);
  assign nBERR  = ~(r_state == S_ABORT);

endmodule

// File: tb/tb_iob_cycle_responder.sv
// Scoreboard bench for iob_cycle_responder with a behavioural IOB-side acknowledger.
module tb_iob_cycle_responder;
  localparam int TO   = 16;
  localparam int SYNC = 2;

  logic CLK = 1'b0, RES = 1'b1, BACT = 1'b0, IOCS = 1'b0, IACS = 1'b0, SCSICS = 1'b0;
  logic IOPWCS = 1'b0, nWE = 1'b1, IOACK = 1'b0;
  logic IOREQ, IOWE, IOIACK, IOSCSI, IOBUSY, nDTACK, nBERR;

  int checks = 0, errors = 0, cyc = 0, both_low = 0;
  int rise_dly = 5, fall_dly = 3, fall_cyc = 0, phase = 0, pcnt = 0;
  bit ack_hold = 0, ack_force = 0, ack_force_val = 0;

  typedef struct packed {logic we; logic iack; logic scsi; logic berr;} exp_t;
  exp_t sb[$];

  iob_cycle_responder #(.TIMEOUT(TO), .SYNC_STAGES(SYNC)) dut (
    .CLK(CLK), .RES(RES), .BACT(BACT), .IOCS(IOCS), .IACS(IACS), .SCSICS(SCSICS),
    .IOPWCS(IOPWCS), .nWE(nWE), .IOACK(IOACK), .IOREQ(IOREQ), .IOWE(IOWE),
    .IOIACK(IOIACK), .IOSCSI(IOSCSI), .IOBUSY(IOBUSY), .nDTACK(nDTACK), .nBERR(nBERR)
  );

  initial forever #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;
  always @(negedge CLK) if (!nDTACK && !nBERR) both_low++;

  // IOB side: ACK rise_dly cycles after REQ, drop fall_dly cycles after REQ drops.
  initial begin
    forever begin
      @(negedge CLK);
      if (ack_force) begin
        if (IOACK && !ack_force_val) fall_cyc = cyc;
        IOACK = ack_force_val;
        phase = 0;
      end else begin
        case (phase)
          0: if (IOREQ && !ack_hold) begin pcnt = 0; phase = 1; end
          1: begin pcnt++; if (pcnt >= rise_dly) begin IOACK = 1'b1; phase = 2; end end
          2: if (!IOREQ) begin pcnt = 0; phase = 3; end
          3: begin pcnt++; if (pcnt >= fall_dly) begin IOACK = 1'b0; fall_cyc = cyc; phase = 0; end end
          default: phase = 0;
        endcase
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic tick;
    @(negedge CLK);
  endtask

  task automatic idle_bus;
    BACT = 0; IOCS = 0; IACS = 0; SCSICS = 0; IOPWCS = 0; nWE = 1;
    repeat (6) tick();
  endtask

  task automatic wait_resp(output bit dt, output bit be, output bit to);
    dt = 0; be = 0; to = 1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!nDTACK || !nBERR) begin dt = !nDTACK; be = !nBERR; to = 0; break; end
    end
  endtask

  task automatic test_reset;
    tick();
    checks++; if (IOREQ !== 1'b0)  begin errors++; $display("FAIL reset_ioreq got %b exp 0", IOREQ); end
    checks++; if (IOWE !== 1'b0)   begin errors++; $display("FAIL reset_iowe got %b exp 0", IOWE); end
    checks++; if (IOIACK !== 1'b0) begin errors++; $display("FAIL reset_ioiack got %b exp 0", IOIACK); end
    checks++; if (IOSCSI !== 1'b0) begin errors++; $display("FAIL reset_ioscsi got %b exp 0", IOSCSI); end
    checks++; if (IOBUSY !== 1'b0) begin errors++; $display("FAIL reset_iobusy got %b exp 0", IOBUSY); end
    checks++; if (nDTACK !== 1'b1) begin errors++; $display("FAIL reset_ndtack got %b exp 1", nDTACK); end
    checks++; if (nBERR !== 1'b1)  begin errors++; $display("FAIL reset_nberr got %b exp 1", nBERR); end
    RES = 0;
    repeat (3) tick();
  endtask

  task automatic test_read;
    bit dt, be, to; exp_t e;
    rise_dly = 5; fall_dly = 3;
    BACT = 1; IOCS = 1; nWE = 1;
    sb.push_back(exp_t'{1'b0, 1'b0, 1'b0, 1'b0});
    tick();
    checks++; if (IOREQ !== 1'b1) begin errors++; $display("FAIL read_ioreq_latency got %b exp 1", IOREQ); end
    wait_resp(dt, be, to);
    checks++; if (to || !dt || be) begin errors++; $display("FAIL read_outcome got dt=%b be=%b to=%b exp dt=1", dt, be, to); end
    checks++; if (cyc - fall_cyc != SYNC + 1) begin errors++; $display("FAIL read_dtack_after_ack got %0d exp %0d", cyc - fall_cyc, SYNC + 1); end
    e = sb.pop_front();
    checks++; if (IOWE !== e.we)     begin errors++; $display("FAIL read_iowe got %b exp %b", IOWE, e.we); end
    checks++; if (IOIACK !== e.iack) begin errors++; $display("FAIL read_ioiack got %b exp %b", IOIACK, e.iack); end
    repeat (3) tick();
    checks++; if (nDTACK !== 1'b0) begin errors++; $display("FAIL read_dtack_hold got %b exp 0", nDTACK); end
    BACT = 0;
    tick();
    checks++; if (nDTACK !== 1'b1) begin errors++; $display("FAIL read_dtack_release got %b exp 1", nDTACK); end
    idle_bus();
  endtask

  task automatic test_timeout;
    int n; exp_t e;
    ack_hold = 1;
    BACT = 1; IOCS = 1; nWE = 1;
    sb.push_back(exp_t'{1'b0, 1'b0, 1'b0, 1'b1});
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (IOREQ) n++;
      else if (n > 0) break;
    end
    checks++; if (n != TO) begin errors++; $display("FAIL timeout_req_cycles got %0d exp %0d", n, TO); end
    e = sb.pop_front();
    checks++; if ((!nBERR) !== e.berr) begin errors++; $display("FAIL timeout_nberr got %b exp %b", nBERR, !e.berr); end
    checks++; if (nDTACK !== 1'b1) begin errors++; $display("FAIL timeout_ndtack got %b exp 1", nDTACK); end
    repeat (5) tick();
    checks++; if (nBERR !== 1'b0) begin errors++; $display("FAIL timeout_berr_hold got %b exp 0", nBERR); end
    BACT = 0;
    tick();
    checks++; if (nBERR !== 1'b1) begin errors++; $display("FAIL timeout_berr_release got %b exp 1", nBERR); end
    ack_hold = 0;
    idle_bus();
  endtask

  task automatic test_iack_scsi;
    bit dt, be, to; exp_t e;
    for (int k = 0; k < 2; k++) begin
      BACT = 1;
      if (k == 0) begin IACS = 1; nWE = 1; sb.push_back(exp_t'{1'b0, 1'b1, 1'b0, 1'b0}); end
      else begin IOCS = 1; SCSICS = 1; nWE = 0; sb.push_back(exp_t'{1'b1, 1'b0, 1'b1, 1'b0}); end
      wait_resp(dt, be, to);
      checks++; if (to || !dt) begin errors++; $display("FAIL iack_scsi_outcome[%0d] got dt=%b to=%b exp dt=1", k, dt, to); end
      e = sb.pop_front();
      checks++; if (IOWE !== e.we)     begin errors++; $display("FAIL iack_scsi_iowe[%0d] got %b exp %b", k, IOWE, e.we); end
      checks++; if (IOIACK !== e.iack) begin errors++; $display("FAIL iack_scsi_ioiack[%0d] got %b exp %b", k, IOIACK, e.iack); end
      checks++; if (IOSCSI !== e.scsi) begin errors++; $display("FAIL iack_scsi_ioscsi[%0d] got %b exp %b", k, IOSCSI, e.scsi); end
      idle_bus();
    end
  endtask

  task automatic test_posted;
    bit dt, be, to; exp_t e;
`ifdef IOB_POSTED_WRITE_EN
    bit early, busy_to;
    rise_dly = 10;
    BACT = 1; IOCS = 1; IOPWCS = 1; nWE = 0;
    sb.push_back(exp_t'{1'b1, 1'b0, 1'b0, 1'b0});
    tick();
    checks++; if (nDTACK !== 1'b0) begin errors++; $display("FAIL posted_dtack_latency got %b exp 0", nDTACK); end
    e = sb.pop_front();
    checks++; if (IOWE !== e.we) begin errors++; $display("FAIL posted_iowe got %b exp %b", IOWE, e.we); end
    BACT = 0; IOCS = 0; IOPWCS = 0; nWE = 1;
    tick();
    checks++; if (nDTACK !== 1'b1) begin errors++; $display("FAIL posted_dtack_release got %b exp 1", nDTACK); end
    checks++; if (IOBUSY !== 1'b1) begin errors++; $display("FAIL posted_busy got %b exp 1", IOBUSY); end
    BACT = 1; IOCS = 1; nWE = 1;
    sb.push_back(exp_t'{1'b0, 1'b0, 1'b0, 1'b0});
    early = 0; busy_to = 1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!nDTACK) early = 1;
      if (!IOBUSY) begin busy_to = 0; break; end
    end
    checks++; if (busy_to || early) begin errors++; $display("FAIL posted_second_wait got early=%b to=%b exp 0 0", early, busy_to); end
    checks++; if (IOREQ !== 1'b0) begin errors++; $display("FAIL posted_second_noreq got %b exp 0", IOREQ); end
    tick();
    checks++; if (IOREQ !== 1'b1) begin errors++; $display("FAIL posted_second_req got %b exp 1", IOREQ); end
    wait_resp(dt, be, to);
    checks++; if (to || !dt) begin errors++; $display("FAIL posted_second_outcome got dt=%b to=%b exp dt=1", dt, to); end
    e = sb.pop_front();
    checks++; if (IOWE !== e.we) begin errors++; $display("FAIL posted_second_iowe got %b exp %b", IOWE, e.we); end
    rise_dly = 5;
`else
    BACT = 1; IOCS = 1; IOPWCS = 1; nWE = 0;
    sb.push_back(exp_t'{1'b1, 1'b0, 1'b0, 1'b0});
    tick();
    checks++; if (nDTACK !== 1'b1) begin errors++; $display("FAIL nopost_early_dtack got %b exp 1", nDTACK); end
    wait_resp(dt, be, to);
    checks++; if (to || !dt) begin errors++; $display("FAIL nopost_outcome got dt=%b to=%b exp dt=1", dt, to); end
    checks++; if (IOBUSY !== 1'b0) begin errors++; $display("FAIL nopost_busy_at_dtack got %b exp 0", IOBUSY); end
    e = sb.pop_front();
    checks++; if (IOWE !== e.we) begin errors++; $display("FAIL nopost_iowe got %b exp %b", IOWE, e.we); end
`endif
    idle_bus();
  endtask

  task automatic test_reset_mid;
    bit dt, be, to; exp_t e;
    ack_hold = 1;
    BACT = 1; IOCS = 1; nWE = 1;
    repeat (3) tick();
    checks++; if (IOREQ !== 1'b1) begin errors++; $display("FAIL rstmid_pre_req got %b exp 1", IOREQ); end
    #2 RES = 1;
    #1;
    checks++; if (IOREQ !== 1'b0)  begin errors++; $display("FAIL rstmid_ioreq got %b exp 0", IOREQ); end
    checks++; if (nDTACK !== 1'b1) begin errors++; $display("FAIL rstmid_ndtack got %b exp 1", nDTACK); end
    checks++; if (nBERR !== 1'b1)  begin errors++; $display("FAIL rstmid_nberr got %b exp 1", nBERR); end
    tick();
    RES = 0; BACT = 0; IOCS = 0; ack_hold = 0;
    repeat (3) tick();
    BACT = 1; IOCS = 1; nWE = 0;
    sb.push_back(exp_t'{1'b1, 1'b0, 1'b0, 1'b0});
    tick();
    checks++; if (IOREQ !== 1'b1) begin errors++; $display("FAIL rstmid_restart_req got %b exp 1", IOREQ); end
    wait_resp(dt, be, to);
    checks++; if (to || !dt) begin errors++; $display("FAIL rstmid_restart_outcome got dt=%b to=%b exp dt=1", dt, to); end
    e = sb.pop_front();
    checks++; if (IOWE !== e.we) begin errors++; $display("FAIL rstmid_restart_iowe got %b exp %b", IOWE, e.we); end
    idle_bus();
  endtask

  task automatic test_stale_ack;
    bit dt, be, to, stuck; exp_t e;
    ack_force = 1; ack_force_val = 1;
    repeat (4) tick();
    BACT = 1; IOCS = 1; nWE = 1;
    sb.push_back(exp_t'{1'b0, 1'b0, 1'b0, 1'b0});
    stuck = 0;
    repeat (6) begin tick(); if (IOREQ) stuck = 1; end
    checks++; if (stuck) begin errors++; $display("FAIL stale_req_during_ack got 1 exp 0"); end
    ack_force_val = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (!IOACK) break; end
    ack_force = 0;
    for (int i = 0; i < 5 && cyc < fall_cyc + SYNC; i++) tick();
    checks++; if (IOREQ !== 1'b0) begin errors++; $display("FAIL stale_req_early got %b exp 0", IOREQ); end
    tick();
    checks++; if (IOREQ !== 1'b1) begin errors++; $display("FAIL stale_req_after_sync got %b exp 1", IOREQ); end
    wait_resp(dt, be, to);
    checks++; if (to || !dt) begin errors++; $display("FAIL stale_outcome got dt=%b to=%b exp dt=1", dt, to); end
    e = sb.pop_front();
    checks++; if (IOWE !== e.we) begin errors++; $display("FAIL stale_iowe got %b exp %b", IOWE, e.we); end
    idle_bus();
  endtask

  initial begin
    test_reset();
    test_read();
    test_timeout();
    test_iack_scsi();
    test_posted();
    test_reset_mid();
    test_stale_ack();
    checks++;
    if (both_low != 0) begin errors++; $display("FAIL dtack_berr_exclusive got %0d overlaps exp 0", both_low); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d left exp 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
